lr_irq: RTL

- Parametrised interrupt controller for the lr35902 core. Replaces the core's single-bit ie flag with a full mechanism:
  - IF (flag) and IE (enable) registers, memory-mapped and accessed over the core's address/data/load/store bus.
  - Edge capture on N request lines.
  - IME state machine with delayed EI.
  - Fixed-priority vector generation and a request/acknowledge handshake with the microcode sequencer.
  - A halt-wake output.

---
 rtl/lr_irq.sv | 90 +++++++++
 1 files changed

// File: rtl/lr_irq.sv
// lr_irq: interrupt controller with IF/IE registers, edge capture, delayed-EI IME and fixed-priority vectoring.
// Ports: clock4/resetn (async active-low) clock and reset.
//        address/indata/load/store/outdata form the core bus; IF and IE are memory-mapped on it.
//        irq_in carries the request lines (rising edge sets IF).
//        ime_set/ime_set_now/ime_clr are the EI/RETI/DI pulses; instr_done marks an instruction boundary.
//        int_req/int_vector/int_ack form the dispatch handshake with the sequencer.
//        wake requests exit from HALT; dime shows IME on.
module lr_irq #(
  parameter int          NUM_IRQ    = 5,
  parameter logic [15:0] VEC_BASE   = 16'h0040,
  parameter int          VEC_STRIDE = 8,
  parameter logic [15:0] IF_ADDR    = 16'hff0f,
  parameter logic [15:0] IE_ADDR    = 16'hffff
) (
  input  logic               clock4,
  input  logic               resetn,
  input  logic [15:0]        address,
  input  logic [7:0]         indata,
  output logic [7:0]         outdata,
  input  logic               load,
  input  logic               store,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               ime_set,
  input  logic               ime_set_now,
  input  logic               ime_clr,
  input  logic               instr_done,
  output logic               int_req,
  output logic [15:0]        int_vector,
  input  logic               int_ack,
  output logic               wake,
  output logic               dime
);
  typedef enum logic [1:0] {OFF, ARM, ON} state_e;
  state_e state_q, state_d;
  logic [NUM_IRQ-1:0] if_q, if_d, prev_q, rise, pending, ack_mask;
  logic [7:0] ie_q, ie_d, outdata_q, outdata_d, if_rd;
  logic int_req_q, int_req_d, ack, if_hit, ie_hit;
  logic [2:0] p;
  always_comb begin
    if_hit = address == IF_ADDR;
    ie_hit = address == IE_ADDR;
    rise = irq_in & ~prev_q;
    pending = if_q & ie_q[NUM_IRQ-1:0];
    ack = int_ack & int_req_q;
    // x & -x isolates the lowest set bit, i.e. the channel being serviced
    ack_mask = ack ? (pending & (~pending + NUM_IRQ'(1))) : '0;
    // edge set beats ack clear, which beats the bus write
    if_d = (((store & if_hit) ? indata[NUM_IRQ-1:0] : if_q) & ~ack_mask) | rise;
    ie_d = (store & ie_hit) ? indata : ie_q;
    if_rd = 8'hff;
    if_rd[NUM_IRQ-1:0] = if_q;
    outdata_d = (load & if_hit) ? if_rd : (load & ie_hit) ? ie_q : outdata_q;
    p = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (pending[i]) p = 3'(i);
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF: state_d = ime_set_now ? ON : ime_set ? ARM : OFF;
      ARM: state_d = (instr_done | ime_set_now) ? ON : ARM;
      ON:  state_d = ack ? OFF : ON;
      default: state_d = OFF;
    endcase
    if (ime_clr) state_d = OFF;
    int_req_d = (state_d == ON) & |(if_d & ie_d[NUM_IRQ-1:0]);
  end
  always_ff @(posedge clock4 or negedge resetn) begin
    if (!resetn) begin
      state_q   <= OFF;
      if_q      <= '0;
      ie_q      <= '0;
      prev_q    <= '0;
      outdata_q <= '0;
      int_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      if_q      <= if_d;
      ie_q      <= ie_d;
      prev_q    <= irq_in;
      outdata_q <= outdata_d;
      int_req_q <= int_req_d;
    end
  end
  assign outdata    = outdata_q;
  assign int_req    = int_req_q;
  assign int_vector = VEC_BASE + 16'(VEC_STRIDE) * {13'd0, p};
  assign wake       = |pending;
  assign dime       = state_q == ON;
endmodule
